baud_tick_gen_rx: RTL

//  Parametrised fractional baud/oversample tick generator for the UART receiver path.

---
 rtl/uart_baud_pkg.sv | 38 +++
 rtl/baud_frac_div.sv | 61 ++++++
 rtl/baud_tick_gen_rx.sv | 93 +++++++++
 3 files changed

// File: rtl/uart_baud_pkg.sv
// Shared constants, baud-select encoding and preset divisor arithmetic for the
// rx-side baud tick generator.
package uart_baud_pkg;

    localparam int unsigned DEF_CLK_HZ     = 18432000;
    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_DIV_W      = 16;
    localparam int unsigned DEF_FRAC_W     = 4;

    typedef enum logic [1:0] {
        Baud2400  = 2'b00,
        Baud4800  = 2'b01,
        Baud9600  = 2'b10,
        Baud38400 = 2'b11
    } baud_sel_e;

    function automatic longint unsigned baud_rate(baud_sel_e sel);
        longint unsigned rate;
        case (sel)
            Baud2400:  rate = 2400;
            Baud4800:  rate = 4800;
            Baud9600:  rate = 9600;
            default:   rate = 38400;
        endcase
        return rate;
    endfunction

    // Returns {int, frac}: clk cycles per os_tick scaled by 2^frac_w, rounded to nearest LSB.
    function automatic longint unsigned preset_div(longint unsigned clk_hz,
                                                   longint unsigned oversample,
                                                   baud_sel_e       sel,
                                                   int unsigned     frac_w = DEF_FRAC_W);
        longint unsigned den;
        den = oversample * baud_rate(sel);
        return ((clk_hz << frac_w) + den / 2) / den;
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional clock divider: counts clk cycles per os_tick, stretching a period by one
// cycle whenever the fractional accumulator carries out.
module baud_frac_div
    import uart_baud_pkg::*;
#(
    parameter int unsigned DIV_W  = DEF_DIV_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [DIV_W-1:0]  eff_int;
    logic [DIV_W-1:0]  last_cnt;
    logic [FRAC_W:0]   sum;
    logic              wrap;

    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, div_frac};
        eff_int  = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
        // eff_int >= 2, so eff_int - 1 + carry always fits in DIV_W bits.
        last_cnt = eff_int - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
        wrap     = (cnt_q == last_cnt);
    end

    assign tick = en && !restart && wrap;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (restart) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (en) begin
            if (wrap) begin
                cnt_d = '0;
                acc_d = sum[FRAC_W-1:0];
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/baud_tick_gen_rx.sv
// UART rx baud tick generator: preset/custom divisor shadowing, oversample phase counter
// and os/mid/bit strobe decode around the fractional divider.
module baud_tick_gen_rx
    import uart_baud_pkg::*;
#(
    parameter int unsigned  CLK_HZ     = DEF_CLK_HZ,
    parameter int unsigned  OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned  DIV_W      = DEF_DIV_W,
    parameter int unsigned  FRAC_W     = DEF_FRAC_W,
    localparam int unsigned PHASE_W    = $clog2(OVERSAMPLE)
) (
    input  logic               clk_rx,
    input  logic               rst,
    input  logic               en,
    input  logic               restart,
    input  logic               use_custom,
    input  logic [1:0]         baud_sel,
    input  logic [DIV_W-1:0]   div_int,
    input  logic [FRAC_W-1:0]  div_frac,
    output logic               os_tick,
    output logic               mid_tick,
    output logic               bit_tick,
    output logic [PHASE_W-1:0] os_phase
);

    localparam int unsigned FIX_W = DIV_W + FRAC_W;
    typedef logic [FIX_W-1:0] fix_t;

    localparam fix_t PRESET_2400  = fix_t'(preset_div(64'(CLK_HZ), 64'(OVERSAMPLE), Baud2400, FRAC_W));
    localparam fix_t PRESET_4800  = fix_t'(preset_div(64'(CLK_HZ), 64'(OVERSAMPLE), Baud4800, FRAC_W));
    localparam fix_t PRESET_9600  = fix_t'(preset_div(64'(CLK_HZ), 64'(OVERSAMPLE), Baud9600, FRAC_W));
    localparam fix_t PRESET_38400 = fix_t'(preset_div(64'(CLK_HZ), 64'(OVERSAMPLE), Baud38400, FRAC_W));

    fix_t               sel_div;
    fix_t               shadow_q, shadow_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               raw_tick;

    always_comb begin
        sel_div = PRESET_9600;
        if (use_custom) begin
            sel_div = {div_int, div_frac};
        end else begin
            case (baud_sel_e'(baud_sel))
                Baud2400:  sel_div = PRESET_2400;
                Baud4800:  sel_div = PRESET_4800;
                Baud9600:  sel_div = PRESET_9600;
                Baud38400: sel_div = PRESET_38400;
            endcase
        end
    end

    // Divisor only changes at a period boundary, so a running period is never distorted.
    assign shadow_d = (restart || raw_tick) ? sel_div : shadow_q;

    always_comb begin
        phase_d = phase_q;
        if (restart) begin
            phase_d = '0;
        end else if (raw_tick) begin
            phase_d = phase_q + PHASE_W'(1);
        end
    end

    always_ff @(posedge clk_rx or negedge rst) begin
        if (!rst) begin
            shadow_q <= PRESET_9600;
            phase_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            phase_q  <= phase_d;
        end
    end

    baud_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .clk      (clk_rx),
        .rst      (rst),
        .en       (en),
        .restart  (restart),
        .div_int  (shadow_q[FIX_W-1:FRAC_W]),
        .div_frac (shadow_q[FRAC_W-1:0]),
        .tick     (raw_tick)
    );

    assign os_tick  = raw_tick;
    assign mid_tick = raw_tick && (phase_q == PHASE_W'(OVERSAMPLE / 2 - 1));
    assign bit_tick = raw_tick && (phase_q == PHASE_W'(OVERSAMPLE - 1));
    assign os_phase = phase_q;

endmodule
